// File: rtl/proc_pkg.sv
// Shared definitions for the processor run controller: FSM state encoding and
// default parameter values.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int DEF_NUM_CORES  = 1;
  localparam int DEF_RST_CYCLES = 3;
  localparam int DEF_RUN_CYCLES = 7;
  localparam int DEF_CNT_W      = 16;

  // Wide enough for RST_CYCLES (<=255) plus the stagger span (<=7).
  localparam int RCNT_W = 9;

endpackage

// File: rtl/proc_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module proc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  // Count register: clear wins over enable, never wraps past MAX_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: holds cores in reset, runs them until halt/abort/timeout.
// Optional macro RUN_CTRL_STAGGER_EN staggers per-core reset release by one cycle.
module proc_run_ctrl
  import proc_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] halt,
  output logic [NUM_CORES-1:0] core_rst_n,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count
);

`ifdef RUN_CTRL_STAGGER_EN
  localparam int RST_LEN = RST_CYCLES + NUM_CORES - 1;
`else
  localparam int RST_LEN = RST_CYCLES;
`endif

  localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0]  RUN_LIM  = CNT_W'(RUN_CYCLES);

  state_t                state;
  state_t                state_nxt;
  logic [RCNT_W-1:0]     rcnt;
  logic [RCNT_W-1:0]     rcnt_nxt;
  logic [NUM_CORES-1:0]  core_nxt;
  logic                  timeout_set;
  logic                  clr_cnt;
  logic                  all_halt;
  logic                  expired;

  assign all_halt = &halt;
  assign expired  = (cycle_count == RUN_LIM);

  // Next state, reset-phase counter and next per-core reset levels.
  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    clr_cnt     = 1'b0;
    rcnt_nxt    = '0;
    core_nxt    = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RESET;
          clr_cnt   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (rcnt == RST_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_RESET;
        end
      end
      // Abort outranks all-halt, which outranks expiry; only expiry flags timeout.
      ST_RUN: begin
        if (abort || all_halt) begin
          state_nxt = ST_FINISH;
        end else if (expired) begin
          state_nxt   = ST_FINISH;
          timeout_set = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if ((state == ST_RESET) && (state_nxt == ST_RESET)) begin
      rcnt_nxt = rcnt + RCNT_W'(1);
    end else begin
      rcnt_nxt = '0;
    end

    case (state_nxt)
      ST_RUN, ST_FINISH: core_nxt = '1;
      ST_RESET: begin
`ifdef RUN_CTRL_STAGGER_EN
        for (int i = 0; i < NUM_CORES; i++) begin
          core_nxt[i] = (rcnt_nxt >= RCNT_W'(RST_CYCLES + i));
        end
`else
        core_nxt = '0;
`endif
      end
      default: core_nxt = '0;
    endcase
  end

  // State and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rcnt       <= '0;
      core_rst_n <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rcnt       <= rcnt_nxt;
      core_rst_n <= core_nxt;
      running    <= (state_nxt == ST_RUN);
      done       <= (state_nxt == ST_FINISH);
      if (clr_cnt) begin
        timeout <= 1'b0;
      end else if (timeout_set) begin
        timeout <= 1'b1;
      end
    end
  end

  proc_sat_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_cnt),
    .en   (state_nxt == ST_RUN),
    .count(cycle_count)
  );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: run scenarios generate expected traces,
// a monitor compares every cycle and every done pulse.
module tb_proc_run_ctrl;

  localparam int NC   = 2;
  localparam int RSTC = 3;
  localparam int RUNC = 7;
  localparam int CW   = 16;
`ifdef RUN_CTRL_STAGGER_EN
  localparam int L = RSTC + NC - 1;
`else
  localparam int L = RSTC;
`endif

  typedef struct packed {
    logic [NC-1:0] crn;
    logic          run;
    logic          dn;
    logic          to;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          to;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [NC-1:0] halt;
  logic [NC-1:0] core_rst_n;
  logic          running;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  exp_t exp_q[$];
  res_t res_q[$];
  logic [CW-1:0] m_cnt;
  logic          m_to;
  int            checks = 0;
  int            errors = 0;
  int            cyc_no = 0;

  always #5 clk = ~clk;

  proc_run_ctrl #(
    .NUM_CORES (NC),
    .RST_CYCLES(RSTC),
    .RUN_CYCLES(RUNC),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .halt       (halt),
    .core_rst_n (core_rst_n),
    .running    (running),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [NC-1:0] rhalt();
    return NC'($urandom);
  endfunction

  function automatic logic [NC-1:0] partial_halt();
    logic [NC-1:0] v;
    v = NC'($urandom);
    if (&v) v[0] = 1'b0;
    return v;
  endfunction

  // One clock: drive inputs for the next edge and queue the outputs expected after it.
  task automatic cyc(input logic s, input logic a, input logic r, input logic [NC-1:0] h,
                     input logic [NC-1:0] crn, input logic rn, input logic dn);
    exp_t e;
    @(negedge clk);
    start = s;
    abort = a;
    rst   = r;
    halt  = h;
    e.crn = crn;
    e.run = rn;
    e.dn  = dn;
    e.to  = m_to;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    m_cnt = '0;
    m_to  = 1'b0;
    cyc(rbit(), rbit(), 1'b1, rhalt(), '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rbit(), 1'b0, rhalt(), '0, 1'b0, 1'b0);
  endtask

  // One run from start: halt all from RUN cycle h_at, abort at RUN cycle a_at,
  // abort at RESET cycle ar_at, rst at RUN cycle r_at (0 = never).
  task automatic run_once(input int h_at, input int a_at, input int ar_at, input int r_at);
    logic [NC-1:0] c;
    logic [NC-1:0] h;
    logic          ab;
    m_cnt = '0;
    m_to  = 1'b0;
    cyc(1'b1, rbit(), 1'b0, rhalt(), '0, 1'b0, 1'b0);
    for (int j = 1; j <= L; j++) begin
      if (j == ar_at) begin
        cyc(rbit(), 1'b1, 1'b0, rhalt(), '0, 1'b0, 1'b0);
        return;
      end
      if (j < L) begin
        for (int i = 0; i < NC; i++) c[i] = (j >= RSTC + i);
        cyc(rbit(), 1'b0, 1'b0, rhalt(), c, 1'b0, 1'b0);
      end else begin
        m_cnt = CW'(1);
        cyc(rbit(), 1'b0, 1'b0, rhalt(), '1, 1'b1, 1'b0);
      end
    end
    for (int k = 1; k <= RUNC; k++) begin
      h  = (h_at != 0 && k >= h_at) ? '1 : partial_halt();
      ab = (k == a_at);
      if (k == r_at) begin
        m_cnt = '0;
        m_to  = 1'b0;
        cyc(rbit(), ab, 1'b1, h, '0, 1'b0, 1'b0);
        return;
      end
      if (ab || (&h) || k == RUNC) begin
        m_to = !ab && !(&h);
        res_q.push_back('{cnt: m_cnt, to: m_to});
        cyc(rbit(), ab, 1'b0, h, '1, 1'b0, 1'b1);
        cyc(rbit(), rbit(), 1'b0, rhalt(), '0, 1'b0, 1'b0);
        return;
      end
      m_cnt = CW'(k + 1);
      cyc(rbit(), 1'b0, 1'b0, h, '1, 1'b1, 1'b0);
    end
  endtask

  // Monitor: per-cycle output check plus end-of-run result check on done.
  always @(posedge clk) begin
    exp_t e;
    res_t r;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({core_rst_n, running, done, timeout, cycle_count} !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d got crn=%b run=%b done=%b to=%b cnt=%0d exp crn=%b run=%b done=%b to=%b cnt=%0d",
                 cyc_no, core_rst_n, running, done, timeout, cycle_count,
                 e.crn, e.run, e.dn, e.to, e.cnt);
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d got done=1 exp no run ending", cyc_no);
      end else begin
        r = res_q.pop_front();
        if (cycle_count !== r.cnt || timeout !== r.to) begin
          errors++;
          $display("FAIL run_result cyc=%0d got cnt=%0d to=%b exp cnt=%0d to=%b",
                   cyc_no, cycle_count, timeout, r.cnt, r.to);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    halt  = '0;
    m_cnt = '0;
    m_to  = 1'b0;
    do_reset();
    do_reset();
    idle(1);
    run_once(4, 0, 0, 0);
    idle(2);
    run_once(0, 0, 0, 0);
    idle(2);
    run_once(5, 0, 0, 0);
    idle(1);
    run_once(0, 2, 0, 0);
    idle(1);
    run_once(0, 0, 2, 0);
    idle(1);
    run_once(0, 0, 0, 3);
    idle(1);
    run_once(RUNC, 0, 0, 0);
    idle(1);
    run_once(5, 5, 0, 0);
    run_once(0, RUNC, 0, 0);
    idle(1);
    run_once(1, 0, 0, 0);
    run_once(0, 0, L, 0);
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) do_reset();
      run_once($urandom_range(0, 9), $urandom_range(0, 12),
               ($urandom_range(0, 9) > 7) ? $urandom_range(1, L) : 0,
               ($urandom_range(0, 11) == 0) ? $urandom_range(1, RUNC) : 0);
    end
    idle(3);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL drain got exp_q=%0d res_q=%0d exp 0 and 0", exp_q.size(), res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
